axi_lite_writer: RTL and testbench
==================================

AXI_LITE_WRITER -- requirements
Module: axi_lite_writer

Interface
REQ-001 Parameter ADDR_W, 32, address width of AWADDR and Write_to.
REQ-002 Parameter DATA_W, 32, data width of WDATA and W_Data; WSTRB width SHALL be DATA_W/8.
REQ-003 ACLK  in  1  sole clock; all logic SHALL be rising-edge ACLK.
REQ-004 ARESET  in  1  reset; synchronous, active-high.
REQ-005 AWVALID  out  1  write-address valid.
REQ-006 AWREADY  in  1  write-address ready from slave.
REQ-007 AWADDR  out  ADDR_W  write address.
REQ-008 AWPROT  out  3  protection; SHALL be tied to 3'b000.
REQ-009 WVALID  out  1  write-data valid.
REQ-010 WREADY  in  1  write-data ready from slave.
REQ-011 WDATA  out  DATA_W  write data.
REQ-012 WSTRB  out  DATA_W/8  byte strobes.
REQ-013 BVALID  in  1  write-response valid.
REQ-014 BREADY  out  1  write-response ready.
REQ-015 BRESP  in  2  write response code.
REQ-016 W_Start  in  1  single-cycle request to start one write.
REQ-017 Write_to  in  ADDR_W  target address, sampled with W_Start.
REQ-018 W_Data  in  DATA_W  data, sampled with W_Start.
REQ-019 W_Strb  in  DATA_W/8  strobes, sampled with W_Start.
REQ-020 Writer_Run  out  1  high while a transaction is in progress.
REQ-021 W_Done  out  1  one-cycle pulse on transaction completion.
REQ-022 W_Resp  out  2  BRESP of the last completed write.
REQ-023 W_Err  out  1  high when last W_Resp != OKAY (2'b00).

Function
REQ-024 FSM states: IDLE, SEND, RESP.
REQ-025 IDLE + W_Start=1: next edge latch Write_to/W_Data/W_Strb into AWADDR/WDATA/WSTRB, set AWVALID=WVALID=Writer_Run=1, go SEND.
REQ-026 W_Start SHALL be ignored in any state other than IDLE; no queuing.
REQ-027 SEND: AWVALID held until AWREADY sampled high, then cleared next edge; WVALID handled independently by WREADY, same rule.
REQ-028 AWADDR, WDATA, WSTRB SHALL be stable while the corresponding VALID is high.
REQ-029 Completion of AW and W tracked by internal done flags; handshakes in the same cycle or in either order SHALL be accepted.
REQ-030 On the edge where both handshakes are complete: BREADY=1, go RESP.
REQ-031 RESP + BVALID=1: next edge BREADY=0, W_Resp=BRESP, W_Err=(BRESP!=2'b00), Writer_Run=0, W_Done=1 for one cycle, go IDLE.
REQ-032 Minimum latency: W_Start at cycle 0, slave always ready -> valids at 1, BREADY at 2, W_Done/Writer_Run low at 3.
REQ-033 Slave stalls of any length SHALL be tolerated; no timeout.
REQ-034 W_Start may be accepted in the cycle W_Done is high (back-to-back).

Reset
REQ-035 ARESET=1: all outputs 0 (AWADDR, WDATA, WSTRB, W_Resp included), state IDLE, done flags cleared, next edge.
REQ-036 Reset mid-transaction SHALL drop all VALID/READY next edge without a W_Done pulse; reset SHALL take priority over W_Start.

Structure
REQ-037 Package axi_lite_pkg SHALL hold the state encoding, response codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11) and default widths.
REQ-038 Single flat module; no sub-module.

Verification
REQ-039 Always-ready slave, W_Start Write_to=0x10 W_Data=0xDEADBEEF W_Strb=0xF -> AW/W handshake cycle 1, W_Done cycle 3, W_Resp=00, W_Err=0.
REQ-040 AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4, AWADDR stable, BREADY only after both done.
REQ-041 Slave BRESP=2'b10 -> W_Resp=10, W_Err=1, W_Done one cycle.
REQ-042 W_Start pulsed during SEND with different data -> ignored; original AWADDR/WDATA completes.
REQ-043 ARESET asserted in RESP with BREADY=1 -> all outputs 0 next edge, no W_Done, next W_Start works normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite single-beat write master:
// state encoding, write response codes and default bus widths.
package axi_lite_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Write master sequencing: wait for a request, push address/data, collect response
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything other than a plain OKAY is reported to the user as an error
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi_lite_writer.sv
// AXI4-Lite write master: issues one address/data beat per W_Start request,
// accepts the AW and W handshakes in any order, then waits for the B response
// and reports it through W_Resp/W_Err with a one-cycle W_Done pulse.
module axi_lite_writer
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // write address channel
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [2:0]            AWPROT,
    // write data channel
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    // write response channel
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP,
    // user side
    input  logic                  W_Start,
    input  logic [ADDR_W-1:0]     Write_to,
    input  logic [DATA_W-1:0]     W_Data,
    input  logic [DATA_W/8-1:0]   W_Strb,
    output logic                  Writer_Run,
    output logic                  W_Done,
    output logic [1:0]            W_Resp,
    output logic                  W_Err
);

    wr_state_t               r_state;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic [ADDR_W-1:0]       r_awaddr;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W/8-1:0]     r_wstrb;
    logic                    r_run;
    logic                    r_done;
    logic [1:0]              r_resp;
    logic                    r_err;
    logic                    r_aw_done;
    logic                    r_w_done;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_aw_complete;
    logic                    w_w_complete;

    // A channel counts as complete if it finished earlier or handshakes this cycle,
    // so both orders and simultaneous handshakes all reach RESP on the same rule.
    assign w_aw_hs       = r_awvalid & AWREADY;
    assign w_w_hs        = r_wvalid & WREADY;
    assign w_aw_complete = r_aw_done | w_aw_hs;
    assign w_w_complete  = r_w_done | w_w_hs;

    assign AWVALID    = r_awvalid;
    assign AWADDR     = r_awaddr;
    assign AWPROT     = 3'b000;
    assign WVALID     = r_wvalid;
    assign WDATA      = r_wdata;
    assign WSTRB      = r_wstrb;
    assign BREADY     = r_bready;
    assign Writer_Run = r_run;
    assign W_Done     = r_done;
    assign W_Resp     = r_resp;
    assign W_Err      = r_err;

    // Transaction sequencer with all bus and status outputs registered
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_resp    <= RESP_OKAY;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (W_Start) begin
                        r_awaddr  <= Write_to;
                        r_wdata   <= W_Data;
                        r_wstrb   <= W_Strb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_run     <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_complete && w_w_complete) begin
                        r_bready  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (BVALID) begin
                        r_bready <= 1'b0;
                        r_resp   <= BRESP;
                        r_err    <= resp_is_err(BRESP);
                        r_run    <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_writer.sv
// Directed bench for axi_lite_writer with a responsive slave model and a
// scoreboard of expected transactions checked at each AW/W/B event.
module tb_axi_lite_writer;

    logic        clk;
    logic        ARESET;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        W_Start;
    logic [31:0] Write_to;
    logic [31:0] W_Data;
    logic [3:0]  W_Strb;
    logic        Writer_Run, W_Done;
    logic [1:0]  W_Resp;
    logic        W_Err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } txn_t;

    txn_t sb[$];

    int checks = 0;
    int errors = 0;

    // slave configuration
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          b_delay  = 0;
    logic [1:0]  cfg_bresp = 2'b00;

    // slave bookkeeping
    logic aw_seen = 1'b0;
    logic w_seen  = 1'b0;

    // monitor counters
    int aw_hi = 0;
    int w_hi  = 0;

    axi_lite_writer #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK       (clk),
        .ARESET     (ARESET),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .AWADDR     (AWADDR),
        .AWPROT     (AWPROT),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .WDATA      (WDATA),
        .WSTRB      (WSTRB),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .BRESP      (BRESP),
        .W_Start    (W_Start),
        .Write_to   (Write_to),
        .W_Data     (W_Data),
        .W_Strb     (W_Strb),
        .Writer_Run (Writer_Run),
        .W_Done     (W_Done),
        .W_Resp     (W_Resp),
        .W_Err      (W_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: decides readies/response at the falling edge from stable DUT outputs
    initial begin
        int aw_cnt;
        int w_cnt;
        int b_cnt;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        forever begin
            @(negedge clk);
            if (ARESET) begin
                AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                aw_seen = 1'b0; w_seen = 1'b0;
            end else begin
                // address channel
                if (AWVALID && !aw_seen) begin
                    if (sb.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
                    else chk("awaddr", AWADDR, sb[0].addr);
                    if (aw_cnt >= aw_delay) begin
                        AWREADY = 1'b1;
                        aw_seen = 1'b1;
                        aw_cnt  = 0;
                    end else begin
                        AWREADY = 1'b0;
                        aw_cnt++;
                    end
                end else begin
                    AWREADY = 1'b0;
                    aw_cnt  = 0;
                end
                // data channel
                if (WVALID && !w_seen) begin
                    if (sb.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
                    else begin
                        chk("wdata", WDATA, sb[0].data);
                        chk("wstrb", WSTRB, sb[0].strb);
                    end
                    if (w_cnt >= w_delay) begin
                        WREADY = 1'b1;
                        w_seen = 1'b1;
                        w_cnt  = 0;
                    end else begin
                        WREADY = 1'b0;
                        w_cnt++;
                    end
                end else begin
                    WREADY = 1'b0;
                    w_cnt  = 0;
                end
                // response channel
                if (BREADY) begin
                    if (!BVALID && b_cnt == 0)
                        chk("bready_after_both", {62'd0, aw_seen, w_seen}, 64'd3);
                    if (b_cnt >= b_delay) begin
                        BVALID  = 1'b1;
                        BRESP   = cfg_bresp;
                        aw_seen = 1'b0;
                        w_seen  = 1'b0;
                        b_cnt   = 0;
                    end else begin
                        BVALID = 1'b0;
                        b_cnt++;
                    end
                end else begin
                    BVALID = 1'b0;
                    BRESP  = 2'b00;
                    b_cnt  = 0;
                end
            end
        end
    end

    // Monitor: valid-duration counters and response check against scoreboard
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (AWVALID) aw_hi++;
            if (WVALID)  w_hi++;
            if (W_Done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("w_resp", W_Resp, e.resp);
                    chk("w_err", W_Err, (e.resp != 2'b00) ? 64'd1 : 64'd0);
                end
            end
        end
    end

    // Drive a request for one cycle; returns at the first cycle after acceptance
    task automatic start_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [1:0] r);
        txn_t t;
        t.addr = a; t.data = d; t.strb = s; t.resp = r;
        sb.push_back(t);
        W_Start = 1'b1; Write_to = a; W_Data = d; W_Strb = s;
        @(negedge clk);
        W_Start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!W_Done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", W_Done, 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awvalid"}, AWVALID, 64'd0);
        chk({tag, "_wvalid"}, WVALID, 64'd0);
        chk({tag, "_bready"}, BREADY, 64'd0);
        chk({tag, "_awaddr"}, AWADDR, 64'd0);
        chk({tag, "_wdata"}, WDATA, 64'd0);
        chk({tag, "_wstrb"}, WSTRB, 64'd0);
        chk({tag, "_awprot"}, AWPROT, 64'd0);
        chk({tag, "_run"}, Writer_Run, 64'd0);
        chk({tag, "_done"}, W_Done, 64'd0);
        chk({tag, "_resp"}, W_Resp, 64'd0);
        chk({tag, "_err"}, W_Err, 64'd0);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ARESET = 1'b1; W_Start = 1'b0; Write_to = '0; W_Data = '0; W_Strb = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        ARESET = 1'b0;
        @(negedge clk);
        $display("step reset done");

        // minimum latency with an always-ready slave
        aw_delay = 0; w_delay = 0; b_delay = 0; cfg_bresp = 2'b00;
        start_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
        chk("lat_awvalid_c1", AWVALID, 64'd1);
        chk("lat_wvalid_c1", WVALID, 64'd1);
        chk("lat_run_c1", Writer_Run, 64'd1);
        @(negedge clk);
        chk("lat_bready_c2", BREADY, 64'd1);
        chk("lat_awvalid_c2", AWVALID, 64'd0);
        @(negedge clk);
        chk("lat_done_c3", W_Done, 64'd1);
        chk("lat_run_c3", Writer_Run, 64'd0);
        chk("lat_bready_c3", BREADY, 64'd0);
        @(negedge clk);
        chk("lat_done_pulse", W_Done, 64'd0);
        $display("step latency write addr=10 data=deadbeef");

        // AWREADY late, WREADY immediate
        aw_delay = 3; aw_hi = 0; w_hi = 0;
        start_write(32'h20, 32'hCAFE0001, 4'h5, 2'b00);
        wait_done();
        chk("aw_hold_cycles", aw_hi, 64'd4);
        chk("w_hold_cycles", w_hi, 64'd1);
        @(negedge clk);
        $display("step delayed awready addr=20");

        // slave error response
        aw_delay = 0; cfg_bresp = 2'b10;
        start_write(32'h30, 32'h01234567, 4'hC, 2'b10);
        wait_done();
        chk("slverr_resp", W_Resp, 64'd2);
        chk("slverr_err", W_Err, 64'd1);
        @(negedge clk);
        chk("slverr_done_pulse", W_Done, 64'd0);
        chk("slverr_err_hold", W_Err, 64'd1);
        $display("step slverr addr=30");

        // W_Start during SEND is ignored
        aw_delay = 5; cfg_bresp = 2'b00;
        start_write(32'h40, 32'h11112222, 4'h3, 2'b00);
        @(negedge clk);
        W_Start = 1'b1; Write_to = 32'h80; W_Data = 32'h99999999; W_Strb = 4'hF;
        @(negedge clk);
        W_Start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("ignore_sb_empty", sb.size(), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("ignore_no_awvalid", AWVALID, 64'd0);
            chk("ignore_no_run", Writer_Run, 64'd0);
        end
        $display("step ignored start addr=40");

        // reset while waiting for the response
        aw_delay = 1; b_delay = 6;
        start_write(32'h50, 32'h55AA55AA, 4'hF, 2'b00);
        n = 0;
        while (!BREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_resp", BREADY, 64'd1);
        ARESET = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        sb.delete();
        W_Start = 1'b1; Write_to = 32'h60; W_Data = 32'h66; W_Strb = 4'h1;
        @(negedge clk);
        W_Start = 1'b0; ARESET = 1'b0;
        chk("rst_priority_run", Writer_Run, 64'd0);
        chk("rst_priority_awvalid", AWVALID, 64'd0);
        @(negedge clk);
        aw_delay = 0; b_delay = 0; cfg_bresp = 2'b01;
        start_write(32'h70, 32'h77777777, 4'h9, 2'b01);
        wait_done();
        chk("post_rst_resp", W_Resp, 64'd1);
        @(negedge clk);
        $display("step reset in resp then addr=70");

        // back-to-back: new request in the W_Done cycle
        cfg_bresp = 2'b00;
        start_write(32'h100, 32'hA0A0A0A0, 4'hF, 2'b00);
        wait_done();
        start_write(32'h104, 32'hB1B1B1B1, 4'h6, 2'b00);
        chk("b2b_run", Writer_Run, 64'd1);
        chk("b2b_awvalid", AWVALID, 64'd1);
        wait_done();
        chk("b2b_err_cleared", W_Err, 64'd0);
        @(negedge clk);
        chk("b2b_sb_empty", sb.size(), 64'd0);
        $display("step back-to-back addr=100,104");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
